// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and types for the SHA-256 datapath.
//   SHA_WORD_W   - message word width
//   SHA_BLK_W    - padded block width
//   SHA_PAD_BYTE - padding marker byte appended after the message
//   pad_state_t  - padder state encoding (FILL, EMIT, EXTRA)
package sha256_pkg;

  localparam int unsigned SHA_WORD_W   = 32;
  localparam int unsigned SHA_BLK_W    = 512;
  localparam logic [7:0]  SHA_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EXTRA
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_merge.sv
// sha256_pad_merge: combinational helper for the final message word.
// Masks bytes n..3 of the word and inserts the 0x80 marker at byte n.
//   word   in  32  message word, byte 0 in [31:24]
//   n      in  3   number of valid bytes (0..4)
//   en     in  1   word is the last of the message; otherwise passthrough
//   merged out 32  masked word with the marker inserted
//   carry  out 1   marker belongs in the next slot (n >= 4)
module sha256_pad_merge
  import sha256_pkg::*;
(
  input  logic [SHA_WORD_W-1:0] word,
  input  logic [2:0]            n,
  input  logic                  en,
  output logic [SHA_WORD_W-1:0] merged,
  output logic                  carry
);

  always_comb begin
    merged = word;
    carry  = 1'b0;
    if (en) begin
      case (n)
        3'd0:    merged = {SHA_PAD_BYTE, 24'h0};
        3'd1:    merged = {word[31:24], SHA_PAD_BYTE, 16'h0};
        3'd2:    merged = {word[31:16], SHA_PAD_BYTE, 8'h0};
        3'd3:    merged = {word[31:8], SHA_PAD_BYTE};
        default: carry  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: collects big-endian 32-bit message words into 512-bit
// blocks and applies SHA-256 padding (0x80 marker, zero fill, 64-bit
// bit length), inserting a pad-only block when the length does not fit.
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      word handshake
//   in_data, in_last       message word, final-word marker
//   in_nbytes              valid bytes in in_data (from MSB)
//   blk_valid/blk_ready    block handshake
//   blk_data               padded block, word 0 in [511:480]
//   blk_first, blk_last    block position within its message
//   err                    sticky protocol error
// Build option: define SHA256_PAD_CHK_EN to enable input protocol checking
// on err; otherwise err is tied low.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  input  logic [2:0]           in_nbytes,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [511:0]         blk_data,
  output logic                 blk_first,
  output logic                 blk_last,
  output logic                 err
);

  localparam int unsigned CNT_W = LEN_W - 3;

  pad_state_t           state;
  logic [3:0]           widx;
  logic [CNT_W-1:0]     byte_cnt;
  logic [CNT_W-1:0]     byte_cnt_next;
  logic                 first_pend;
  logic                 pend_extra;
  logic                 pad_placed;
  logic [2:0]           n_eff;
  logic [31:0]          merged;
  logic                 carry;
  logic                 carry_in_blk;
  logic                 extra_needed;
  logic [LEN_W-1:0]     len_next;
  logic [LEN_W-1:0]     len_cur;
  logic [SHA_BLK_W-1:0] fill_next;
  logic [SHA_BLK_W-1:0] extra_blk;

`ifdef SHA256_PAD_CHK_EN
  logic bad_word;
  assign bad_word = (in_nbytes > 3'd4) || (!in_last && (in_nbytes != 3'd4));
  assign n_eff    = bad_word ? 3'd4 : in_nbytes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == FILL) && in_valid && bad_word) begin
      err <= 1'b1;
    end
  end
`else
  assign n_eff = in_nbytes;
  assign err   = 1'b0;
`endif

  sha256_pad_merge u_merge (
    .word   (in_data),
    .n      (n_eff),
    .en     (in_last),
    .merged (merged),
    .carry  (carry)
  );

  assign byte_cnt_next = byte_cnt + CNT_W'(n_eff);
  assign len_next      = {byte_cnt_next, 3'b000};
  assign len_cur       = {byte_cnt, 3'b000};
  // A carried marker at slot 15 would fall outside this block.
  assign carry_in_blk  = carry && (widx != 4'd15);
  // Length needs slots 14..15 free after the marker slot.
  assign extra_needed  = carry ? (widx >= 4'd13) : (widx >= 4'd14);

  // Next block buffer when a word is accepted in FILL.
  always_comb begin
    fill_next = blk_data;
    for (int unsigned i = 0; i < 16; i++) begin
      if (4'(i) == widx) begin
        fill_next[SHA_BLK_W-1-32*i -: 32] = merged;
      end else if (in_last && (4'(i) > widx)) begin
        if (carry_in_blk && (4'(i) == widx + 4'd1)) begin
          fill_next[SHA_BLK_W-1-32*i -: 32] = {SHA_PAD_BYTE, 24'h0};
        end else begin
          fill_next[SHA_BLK_W-1-32*i -: 32] = '0;
        end
      end
    end
    if (in_last && !extra_needed) begin
      fill_next[LEN_W-1:0] = len_next;
    end
  end

  always_comb begin
    extra_blk = '0;
    if (!pad_placed) begin
      extra_blk[SHA_BLK_W-1 -: 32] = {SHA_PAD_BYTE, 24'h0};
    end
    extra_blk[LEN_W-1:0] = len_cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      widx       <= '0;
      byte_cnt   <= '0;
      first_pend <= 1'b1;
      pend_extra <= 1'b0;
      pad_placed <= 1'b0;
      in_ready   <= 1'b1;
      blk_valid  <= 1'b0;
      blk_data   <= '0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            blk_data <= fill_next;
            byte_cnt <= byte_cnt_next;
            widx     <= widx + 4'd1;
            if (in_last || (widx == 4'd15)) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
              blk_first <= first_pend;
            end
            if (in_last) begin
              blk_last   <= !extra_needed;
              pend_extra <= extra_needed;
              pad_placed <= !(carry && (widx == 4'd15));
            end else begin
              blk_last   <= 1'b0;
              pend_extra <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (pend_extra) begin
              state      <= EXTRA;
              blk_data   <= extra_blk;
              blk_first  <= 1'b0;
              blk_last   <= 1'b1;
              pend_extra <= 1'b0;
              first_pend <= 1'b0;
            end else begin
              state      <= FILL;
              widx       <= '0;
              in_ready   <= 1'b1;
              blk_valid  <= 1'b0;
              blk_first  <= 1'b0;
              blk_last   <= 1'b0;
              first_pend <= blk_last;
              if (blk_last) begin
                byte_cnt <= '0;
              end
            end
          end
        end
        EXTRA: begin
          if (blk_ready) begin
            state      <= FILL;
            widx       <= '0;
            byte_cnt   <= '0;
            in_ready   <= 1'b1;
            blk_valid  <= 1'b0;
            blk_last   <= 1'b0;
            first_pend <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed self-checking bench for sha256_padder.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         err;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int unsigned i,
                                       input logic [31:0] w);
    b[511-32*i -: 32] = w;
    return b;
  endfunction

  function automatic logic [31:0] pw(input int unsigned i);
    return {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)} ^ 32'h5A5A0000;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] n);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = l;
    in_nbytes = n;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [511:0] exp, input logic ef,
                      input logic el, input logic immediate);
    int t = 0;
    if (immediate) chk({tag, "_valid_now"}, 512'(blk_valid), 512'(1'b1));
    while (!blk_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!immediate) chk({tag, "_valid"}, 512'(blk_valid), 512'(1'b1));
    chk({tag, "_data"}, blk_data, exp);
    chk({tag, "_first"}, 512'(blk_first), 512'(ef));
    chk({tag, "_last"}, 512'(blk_last), 512'(el));
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(1'b0));
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(1'b1));
    chk({tag, "_blk_valid"}, 512'(blk_valid), 512'(1'b0));
    chk({tag, "_blk_data"}, blk_data, '0);
    chk({tag, "_blk_first"}, 512'(blk_first), 512'(1'b0));
    chk({tag, "_blk_last"}, 512'(blk_last), 512'(1'b0));
    chk({tag, "_err"}, 512'(err), 512'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp;
    logic [511:0] abc_blk;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = 3'd4;
    blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // "abc"
    abc_blk = put(put('0, 0, 32'h61626380), 15, 32'h00000018);
    send_word(32'h61626300, 1'b1, 3'd3);
    recv("abc", abc_blk, 1'b1, 1'b1, 1'b1);

    // Empty message; garbage in the masked bytes must not leak through
    send_word(32'hDEADBEEF, 1'b1, 3'd0);
    recv("empty", put('0, 0, 32'h80000000), 1'b1, 1'b1, 1'b1);

    // 55 bytes: marker lands in byte 3 of word 13, length 0x1B8
    exp = '0;
    for (int unsigned i = 0; i < 13; i++) begin
      send_word(pw(i), 1'b0, 3'd4);
      exp = put(exp, i, pw(i));
    end
    send_word(32'hAABBCCDD, 1'b1, 3'd3);
    exp = put(exp, 13, 32'hAABBCC80);
    exp = put(exp, 15, 32'h000001B8);
    recv("b55", exp, 1'b1, 1'b1, 1'b1);

    // 56 bytes: marker in word 14, length needs a pad-only block
    exp = '0;
    for (int unsigned i = 0; i < 13; i++) begin
      send_word(pw(i), 1'b0, 4'd4);
      exp = put(exp, i, pw(i));
    end
    send_word(pw(13), 1'b1, 3'd4);
    exp = put(exp, 13, pw(13));
    exp = put(exp, 14, 32'h80000000);
    recv("b56_1", exp, 1'b1, 1'b0, 1'b1);
    recv("b56_2", put('0, 15, 32'h000001C0), 1'b0, 1'b1, 1'b1);

    // 64 bytes: full data block, then marker plus length block
    exp = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      send_word(pw(i), 1'b0, 3'd4);
      exp = put(exp, i, pw(i));
    end
    send_word(pw(15), 1'b1, 3'd4);
    exp = put(exp, 15, pw(15));
    recv("b64_1", exp, 1'b1, 1'b0, 1'b1);
    recv("b64_2", put(put('0, 0, 32'h80000000), 15, 32'h00000200), 1'b0, 1'b1, 1'b1);

    // Backpressure: block held stable, input stalled
    send_word(32'h61626300, 1'b1, 3'd3);
    for (int unsigned c = 0; c < 5; c++) begin
      chk("bp_data", blk_data, abc_blk);
      chk("bp_in_ready", 512'(in_ready), 512'(1'b0));
      chk("bp_valid", 512'(blk_valid), 512'(1'b1));
      @(negedge clk);
    end
    recv("bp", abc_blk, 1'b1, 1'b1, 1'b1);

    // Reset with widx=7: outputs return to reset values asynchronously
    for (int unsigned i = 0; i < 7; i++) begin
      send_word(pw(i), 1'b0, 3'd4);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(32'h61626300, 1'b1, 3'd3);
    recv("post_rst", abc_blk, 1'b1, 1'b1, 1'b1);

    chk("err_final", 512'(err), 512'(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
